// File: rtl/step_dir_gen_pkg.sv
// Shared types for the step/dir trapezoidal pulse generator.
// FSM states, ramp modes and the DIR setup counter width.
package step_dir_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        RM_CRUISE,
        RM_ACCEL,
        RM_DECEL
    } ramp_t;

    localparam int SET_W = 8;

endpackage

// File: rtl/step_dir_gen_if.sv
// Move-command handshake: signed relative steps plus cruise period.
// The controller side drives valid/payload, the generator drives ready.
interface step_dir_gen_if #(
    parameter int POS_W = 32,
    parameter int PER_W = 16
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [POS_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_per_min;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_per_min,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_per_min,
        output cmd_ready
    );
endinterface

// File: rtl/step_dir_gen_step_timer.sv
// Step interval down-counter: loads the period on start, flags the
// STEP high window and the last cycle of the interval.
module step_timer #(
    parameter int PER_W   = 16,
    parameter int PULSE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [PER_W-1:0] i_period,
    output logic             o_pulse_high,
    output logic             o_interval_end
);

    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_hi  <= '0;
        end else if (i_start) begin
            r_cnt <= i_period;
            r_hi  <= PER_W'(PULSE_W);
        end else begin
            if (r_cnt != '0) r_cnt <= r_cnt - PER_W'(1);
            if (r_hi != '0)  r_hi  <= r_hi - PER_W'(1);
        end
    end

    assign o_pulse_high   = (r_hi != '0);
    assign o_interval_end = (r_cnt == PER_W'(1));

endmodule

// File: rtl/step_dir_gen.sv
// Trapezoidal step/dir generator: accepts a signed relative move and
// emits STEP pulses with accel/cruise/decel, DIR and a position count.
module step_dir_gen
    import step_dir_gen_pkg::*;
#(
    parameter int POS_W        = 32,
    parameter int PER_W        = 16,
    parameter int START_PERIOD = 100,
    parameter int ACCEL_DEC    = 10,
    parameter int PULSE_W      = 4,
    parameter int DIR_SETUP    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    step_dir_gen_if.slave    cmd,
    input  logic             stop,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);

    localparam logic [PER_W:0] C_START = (PER_W+1)'(START_PERIOD);
    localparam logic [PER_W:0] C_ACC   = (PER_W+1)'(ACCEL_DEC);
    localparam logic [PER_W:0] C_PLO   = (PER_W+1)'(PULSE_W + 1);
    localparam logic [SET_W-1:0] C_SET = SET_W'(DIR_SETUP - 1);

    state_t           r_state;
    state_t           w_nxt;
    logic             r_ready;
    logic             r_dir;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_rem;
    logic [POS_W-1:0] r_ramp;
    logic [PER_W:0]   r_per;
    logic [PER_W:0]   r_pmin;
    logic [SET_W-1:0] r_set;

    logic             w_accept;
    logic             w_start;
    logic             w_tmr_end;
    logic             w_pulse;
    logic [POS_W-1:0] w_abs;
    logic [POS_W-1:0] w_rem_dec;
    logic [POS_W-1:0] w_rem_nx;
    logic [POS_W-1:0] w_ramp_nx;
    logic [PER_W:0]   w_pm_ext;
    logic [PER_W:0]   w_pmin_in;
    logic [PER_W:0]   w_up;
    logic [PER_W:0]   w_dn;
    logic [PER_W:0]   w_floor;
    logic [PER_W:0]   w_per_nx;
    ramp_t            w_mode;

    assign w_accept = cmd.cmd_valid && r_ready;
    assign w_start  = (r_state == S_SETUP && r_set == '0) ||
                      (r_state == S_RUN && w_tmr_end && r_rem != '0);
    assign w_abs    = cmd.cmd_steps[POS_W-1] ?
                      (~cmd.cmd_steps + POS_W'(1)) : cmd.cmd_steps;

    always_comb begin
        w_pm_ext  = {1'b0, cmd.cmd_per_min};
        w_pmin_in = w_pm_ext;
        if (w_pm_ext < C_PLO)        w_pmin_in = C_PLO;
        else if (w_pm_ext > C_START) w_pmin_in = C_START;
    end

    // Stop shrinks the remaining count to the decel length, never grows it.
    always_comb begin
        w_rem_dec = r_rem - POS_W'(1);
        w_rem_nx  = w_rem_dec;
        if (stop && r_state == S_RUN && r_ramp < w_rem_dec)
            w_rem_nx = r_ramp;
        w_up      = r_per + C_ACC;
        w_dn      = r_per - C_ACC;
        w_floor   = r_pmin + C_ACC;
        w_mode    = RM_CRUISE;
        if (w_rem_nx <= r_ramp)  w_mode = RM_DECEL;
        else if (r_per > r_pmin) w_mode = RM_ACCEL;
        w_per_nx  = r_per;
        w_ramp_nx = r_ramp;
        case (w_mode)
            RM_DECEL: begin
                w_per_nx  = (w_up > C_START) ? C_START : w_up;
                w_ramp_nx = (r_ramp == '0) ? r_ramp : r_ramp - POS_W'(1);
            end
            RM_ACCEL: begin
                w_per_nx  = (r_per >= w_floor) ? w_dn : r_pmin;
                w_ramp_nx = r_ramp + POS_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                w_nxt = S_IDLE;
                if (w_accept)
                    w_nxt = (cmd.cmd_steps == '0) ? S_DONE : S_SETUP;
            end
            S_SETUP: if (r_set == '0) w_nxt = S_RUN;
            S_RUN:   if (w_tmr_end && r_rem == '0) w_nxt = S_DONE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_dir   <= 1'b0;
            r_pos   <= '0;
            r_rem   <= '0;
            r_ramp  <= '0;
            r_per   <= C_START;
            r_pmin  <= C_START;
            r_set   <= '0;
        end else begin
            r_ready <= (w_nxt == S_IDLE) || (w_nxt == S_DONE);
            if (w_accept) begin
                r_dir  <= ~cmd.cmd_steps[POS_W-1];
                r_rem  <= w_abs;
                r_ramp <= '0;
                r_per  <= C_START;
                r_pmin <= w_pmin_in;
                r_set  <= C_SET;
            end else if (w_start) begin
                r_pos  <= r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
                r_rem  <= w_rem_nx;
                r_ramp <= w_ramp_nx;
                r_per  <= w_per_nx;
            end else if (r_state == S_SETUP) begin
                r_set  <= r_set - SET_W'(1);
            end
        end
    end

    step_timer #(
        .PER_W   (PER_W),
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (w_start),
        .i_period       (w_per_nx[PER_W-1:0]),
        .o_pulse_high   (w_pulse),
        .o_interval_end (w_tmr_end)
    );

    assign cmd.cmd_ready = r_ready;
    assign step          = w_pulse;
    assign dir           = r_dir;
    assign busy          = (r_state == S_SETUP) || (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign position      = r_pos;

endmodule
